spi_slave_tx_64: RTL and testbench

- 64-bit SPI slave transmitter: the MISO-side counterpart of the SPI_Slave_64 receiver.
- Accepts 64-bit words from the raytracing controller through a valid/ready handshake and buffers them in a small FIFO.
- Shifts words out MSB-first on MISO whenever the MCU master clocks a frame.
- Runs in the 100 MHz domain and oversamples SCK/CS; o_TX_Pending drives the MCU interrupt line (ck_a0).

---
 rtl/spi_slave_tx_64_pkg.sv | 9 +
 rtl/spi_slave_tx_64_if.sv | 13 +
 rtl/spi_slave_tx_64_fifo.sv | 42 ++++
 rtl/spi_slave_tx_64.sv | 141 ++++++++++++++
 tb/tb_spi_slave_tx_64.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_tx_64_pkg.sv
// Shared constants and state type for the 64-bit SPI slave transmitter.
package spi_pkg;

  localparam int unsigned WORD_W   = 64;
  localparam int unsigned BITCNT_W = $clog2(WORD_W);

  typedef enum logic {IDLE, SHIFT} spi_tx_state_t;

endpackage

// File: rtl/spi_slave_tx_64_if.sv
// Controller-to-transmitter word handshake (valid/ready).
interface spi_slave_tx_64_if #(
  parameter int unsigned WORD_W = 64
);

  logic              tx_dv;
  logic [WORD_W-1:0] tx_word;
  logic              tx_ready;

  modport master (output tx_dv, output tx_word, input tx_ready);
  modport slave  (input tx_dv, input tx_word, output tx_ready);

endinterface

// File: rtl/spi_slave_tx_64_fifo.sv
// Synchronous word FIFO; pointers carry an extra MSB to tell full from empty.
module spi_tx_fifo #(
  parameter int unsigned WORD_W     = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [WORD_W-1:0]             push_data,
  input  logic                          pop,
  output logic [WORD_W-1:0]             head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/spi_slave_tx_64.sv
// SPI mode-0 slave transmitter: FIFO-buffered 64-bit words shifted MSB-first on MISO,
// with SCK/CS oversampled in the system clock domain.
module spi_slave_tx_64
  import spi_pkg::*;
#(
  parameter int unsigned WORD_W      = spi_pkg::WORD_W,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst_L,
  spi_slave_tx_64_if.slave              tx,
  output logic                          o_TX_Pending,
  output logic [$clog2(FIFO_DEPTH):0]   o_TX_Level,
  output logic                          o_TX_Done,
  output logic                          o_Underrun,
  output logic                          o_Abort,
  input  logic                          i_SPI_Clk,
  input  logic                          i_SPI_CS_n,
  output logic                          o_SPI_MISO,
  output logic                          o_SPI_MISO_En
);

  localparam int unsigned        CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WORD_W - 1);

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync;
  logic                   sck_d, cs_d;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall;

  spi_tx_state_t     state;
  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              cur_real, wrap;
  logic              tx_done, underrun, abort;

  logic              load_slot;
  logic [WORD_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty;

  // CS synchronizer resets high so an idle bus never looks like a falling edge.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sck_sync <= '0;
      cs_sync  <= '1;
      sck_d    <= 1'b0;
      cs_d     <= 1'b1;
    end else begin
      sck_sync[0] <= i_SPI_Clk;
      cs_sync[0]  <= i_SPI_CS_n;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sck_sync[i] <= sck_sync[i-1];
        cs_sync[i]  <= cs_sync[i-1];
      end
      sck_d <= sck_sync[SYNC_STAGES-1];
      cs_d  <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sck_rise = sck_sync[SYNC_STAGES-1] & ~sck_d;
  assign sck_fall = ~sck_sync[SYNC_STAGES-1] & sck_d;
  assign cs_rise  = cs_sync[SYNC_STAGES-1] & ~cs_d;
  assign cs_fall  = ~cs_sync[SYNC_STAGES-1] & cs_d;

  assign load_slot = !cs_rise &&
                     (((state == IDLE) && cs_fall) || ((state == SHIFT) && sck_fall && wrap));

  // Pop sees the registered empty flag, so a same-cycle push cannot satisfy this load.
  spi_tx_fifo #(
    .WORD_W     (WORD_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_Clk),
    .rst_n     (i_Rst_L),
    .push      (tx.tx_dv),
    .push_data (tx.tx_word),
    .pop       (load_slot),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (o_TX_Level)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      cur_real <= 1'b0;
      wrap     <= 1'b0;
      tx_done  <= 1'b0;
      underrun <= 1'b0;
      abort    <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      underrun <= 1'b0;
      abort    <= 1'b0;
      if (cs_rise) begin
        abort   <= (bit_cnt != '0);
        bit_cnt <= '0;
        wrap    <= 1'b0;
        state   <= IDLE;
      end else begin
        if (load_slot) begin
          shreg    <= fifo_empty ? '0 : fifo_head;
          cur_real <= !fifo_empty;
          underrun <= fifo_empty;
          wrap     <= 1'b0;
        end
        case (state)
          IDLE: begin
            if (cs_fall) state <= SHIFT;
          end
          SHIFT: begin
            if (sck_rise) begin
              if (bit_cnt == LAST) begin
                bit_cnt <= '0;
                tx_done <= cur_real;
                wrap    <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end else if (sck_fall && !wrap) begin
              shreg <= {shreg[WORD_W-2:0], 1'b0};
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign tx.tx_ready    = !fifo_full;
  assign o_TX_Pending   = !fifo_empty;
  assign o_TX_Done      = tx_done;
  assign o_Underrun     = underrun;
  assign o_Abort        = abort;
  assign o_SPI_MISO_En  = (state == SHIFT);
  assign o_SPI_MISO     = (state == SHIFT) & shreg[WORD_W-1];

endmodule

// File: tb/tb_spi_slave_tx_64.sv
// Directed bench for spi_slave_tx_64: frames driven at i_Clk/10, MISO captured on SCK rise.
module tb_spi_slave_tx_64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sck;
  logic        cs_n;
  logic        pending, done, underrun, abort, miso, miso_en;
  logic [2:0]  level;

  int unsigned n_run  = 0;
  int unsigned n_fail = 0;
  int unsigned done_cnt = 0, under_cnt = 0, abort_cnt = 0;

  logic [127:0] got;
  logic [2:0]   lvl_at [128];
  logic         en_seen;

  localparam logic [63:0] W0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] W1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] W2 = 64'hA5A5_5A5A_F00F_0FF0;
  localparam logic [63:0] W3 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] W4 = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  spi_slave_tx_64_if #(.WORD_W(64)) tx_if ();

  spi_slave_tx_64 #(
    .WORD_W      (64),
    .FIFO_DEPTH  (4),
    .SYNC_STAGES (2)
  ) dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .tx            (tx_if),
    .o_TX_Pending  (pending),
    .o_TX_Level    (level),
    .o_TX_Done     (done),
    .o_Underrun    (underrun),
    .o_Abort       (abort),
    .i_SPI_Clk     (sck),
    .i_SPI_CS_n    (cs_n),
    .o_SPI_MISO    (miso),
    .o_SPI_MISO_En (miso_en)
  );

  always @(negedge clk) begin
    if (done)     done_cnt++;
    if (underrun) under_cnt++;
    if (abort)    abort_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] w);
    @(negedge clk);
    tx_if.tx_dv   = 1'b1;
    tx_if.tx_word = w;
    @(negedge clk);
    tx_if.tx_dv   = 1'b0;
  endtask

  // The last SCK fall and the CS rise change together, so CS rise wins that cycle.
  task automatic frame(input int unsigned nsck);
    got = '0;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    en_seen = miso_en;
    for (int unsigned i = 0; i < nsck; i++) begin
      got = {got[126:0], miso};
      if (i < 128) lvl_at[i] = level;
      sck = 1'b1;
      repeat (5) @(negedge clk);
      sck = 1'b0;
      if (i == nsck - 1) cs_n = 1'b1;
      repeat (5) @(negedge clk);
    end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int unsigned d0, u0, a0;
    rst_n = 1'b0;
    sck   = 1'b0;
    cs_n  = 1'b1;
    tx_if.tx_dv   = 1'b0;
    tx_if.tx_word = '0;
    repeat (3) @(negedge clk);
    check("rst_ready",   tx_if.tx_ready, 1);
    check("rst_pending", pending, 0);
    check("rst_level",   level, 0);
    check("rst_miso_en", miso_en, 0);
    check("rst_miso",    miso, 0);
    check("rst_pulses",  {done, underrun, abort}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single word
    push(64'hDEAD_BEEF_0123_4567);
    check("t1_pending_before", pending, 1);
    d0 = done_cnt; u0 = under_cnt;
    frame(64);
    check("t1_en",      en_seen, 1);
    check("t1_bits",    got[63:0], 64'hDEAD_BEEF_0123_4567);
    check("t1_done",    done_cnt - d0, 1);
    check("t1_under",   under_cnt - u0, 0);
    check("t1_pending_after", pending, 0);
    check("t1_en_idle", miso_en, 0);

    // Back-to-back words in one frame
    push(64'h1);
    push(64'h8000_0000_0000_0000);
    check("t2_level2", level, 2);
    d0 = done_cnt; u0 = under_cnt;
    frame(128);
    check("t2_bits",   got, {64'h1, 64'h8000_0000_0000_0000});
    check("t2_level1", lvl_at[0], 1);
    check("t2_level0", lvl_at[64], 0);
    check("t2_done",   done_cnt - d0, 2);
    check("t2_under",  under_cnt - u0, 0);

    // Empty FIFO frame
    d0 = done_cnt; u0 = under_cnt;
    frame(64);
    check("t3_bits",  got[63:0], 0);
    check("t3_under", under_cnt - u0, 1);
    check("t3_done",  done_cnt - d0, 0);

    // Fill to capacity; fifth word must be dropped
    push(W0); push(W1); push(W2);
    check("t4_ready3", tx_if.tx_ready, 1);
    push(W3);
    check("t4_ready4", tx_if.tx_ready, 0);
    check("t4_level4", level, 4);
    push(W4);
    check("t4_level5", level, 4);
    check("t4_pending", pending, 1);

    // Abort after 20 SCKs: W0 is dropped, W1 follows
    d0 = done_cnt; a0 = abort_cnt;
    frame(20);
    check("t5_partial", got[19:0], 20'h01234);
    check("t5_abort",   abort_cnt - a0, 1);
    check("t5_done",    done_cnt - d0, 0);
    check("t5_level",   level, 3);
    frame(64);
    check("t5_next",    got[63:0], W1);
    frame(64);
    check("t5_w2",      got[63:0], W2);
    u0 = under_cnt;
    frame(64);
    check("t5_w3",      got[63:0], W3);
    check("t5_level0",  level, 0);
    check("t5_no_under", under_cnt - u0, 0);
    frame(64);
    check("t4_w4_absent", got[63:0], 0);
    check("t4_w4_under",  under_cnt - u0, 1);

    // Reset mid-frame at bit 30
    push(W2);
    push(W3);
    @(negedge clk);
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int unsigned i = 0; i < 30; i++) begin
      sck = 1'b1; repeat (5) @(negedge clk);
      sck = 1'b0; repeat (5) @(negedge clk);
    end
    sck = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_en_before", miso_en, 1);
    check("t6_level_before", level, 1);
    rst_n = 1'b0;
    #1;
    check("t6_ready",   tx_if.tx_ready, 1);
    check("t6_pending", pending, 0);
    check("t6_level",   level, 0);
    check("t6_en",      miso_en, 0);
    check("t6_miso",    miso, 0);
    check("t6_pulses",  {done, underrun, abort}, 0);
    sck  = 1'b0;
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t6_level_after", level, 0);

    // Abort with nothing queued: zeros plus underrun
    u0 = under_cnt; a0 = abort_cnt;
    frame(20);
    check("t7_bits",  got[19:0], 0);
    check("t7_under", under_cnt - u0, 1);
    check("t7_abort", abort_cnt - a0, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
